// File: rtl/router_dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// router_dispatch_ctrl
//
// Steers a valid/ready packet stream (header beat plus optional payload beats)
// onto one of two output ports. The destination is taken from bits [1:0] of
// the header beat: 00 selects port 0, 01 selects port 1, and 10/11 are invalid.
// The path stays locked to the selected port until the packet's last beat.
// Packets with an invalid destination are consumed and discarded. Saturating
// counters track the packets accepted for each port and the packets dropped.
//
// Ports
//   i_clk, i_rst_n          rising-edge clock, asynchronous active-low reset
//   i_in_valid / o_in_ready upstream handshake
//   i_in_data, i_in_last    upstream beat data and end-of-packet flag
//   o_outN_valid/i_outN_ready, o_outN_data, o_outN_last   port N (N = 0, 1)
//   o_busy                  registered; high while in ROUTE or DROP
//   o_cur_port              port locked for the current packet (valid in ROUTE)
//   o_pkt_cnt0/1, o_drop_cnt  saturating statistics counters
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a header beat; decodes the destination
// ROUTE  | forwarding payload beats to the locked port until the last beat
// DROP   | discarding the beats of a packet with an invalid destination
// ----------------------------------------------------------------------------
module router_dispatch_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_last,
    output logic              o_out0_valid,
    input  logic              i_out0_ready,
    output logic [DATA_W-1:0] o_out0_data,
    output logic              o_out0_last,
    output logic              o_out1_valid,
    input  logic              i_out1_ready,
    output logic [DATA_W-1:0] o_out1_data,
    output logic              o_out1_last,
    output logic              o_busy,
    output logic              o_cur_port,
    output logic [CNT_W-1:0]  o_pkt_cnt0,
    output logic [CNT_W-1:0]  o_pkt_cnt1,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_cur_port;
    logic              w_port_nxt;
    logic              r_busy;

    logic              r_out0_valid;
    logic [DATA_W-1:0] r_out0_data;
    logic              r_out0_last;
    logic              r_out1_valid;
    logic [DATA_W-1:0] r_out1_data;
    logic              r_out1_last;

    logic [CNT_W-1:0]  r_pkt_cnt0;
    logic [CNT_W-1:0]  r_pkt_cnt1;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_hdr_ok;
    logic              w_hdr_port;
    logic              w_can0;
    logic              w_can1;
    logic              w_in_ready;
    logic              w_tgt;
    logic              w_load;
    logic              w_inc_pkt;
    logic              w_inc_drop;
    logic              w_load0;
    logic              w_load1;
    logic              w_inc0;
    logic              w_inc1;

    // Header decode: bit 1 set marks an invalid destination, bit 0 picks the port.
    assign w_hdr_ok   = ~i_in_data[1];
    assign w_hdr_port = i_in_data[0];

    // A port register can take a beat when empty or when it drains this cycle.
    assign w_can0 = ~r_out0_valid | i_out0_ready;
    assign w_can1 = ~r_out1_valid | i_out1_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_cur_port;
        w_in_ready  = 1'b0;
        w_tgt       = r_cur_port;
        w_load      = 1'b0;
        w_inc_pkt   = 1'b0;
        w_inc_drop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hdr_ok) begin
                    w_tgt      = w_hdr_port;
                    w_in_ready = w_hdr_port ? w_can1 : w_can0;
                    if (i_in_valid && w_in_ready) begin
                        w_load     = 1'b1;
                        w_port_nxt = w_hdr_port;
                        if (i_in_last) begin
                            w_inc_pkt = 1'b1;
                        end else begin
                            w_state_nxt = S_ROUTE;
                        end
                    end
                end else begin
                    w_in_ready = 1'b1;
                    if (i_in_valid) begin
                        if (i_in_last) begin
                            w_inc_drop = 1'b1;
                        end else begin
                            w_state_nxt = S_DROP;
                        end
                    end
                end
            end
            S_ROUTE: begin
                w_in_ready = r_cur_port ? w_can1 : w_can0;
                if (i_in_valid && w_in_ready) begin
                    w_load = 1'b1;
                    if (i_in_last) begin
                        w_inc_pkt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                w_in_ready = 1'b1;
                if (i_in_valid && i_in_last) begin
                    w_inc_drop  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_load0 = w_load & ~w_tgt;
    assign w_load1 = w_load &  w_tgt;
    assign w_inc0  = w_inc_pkt & ~w_tgt;
    assign w_inc1  = w_inc_pkt &  w_tgt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cur_port <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_port <= w_port_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    // Output registers: a load wins over a drain, so a simultaneous load and
    // drain keeps valid high with the new beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out0_valid <= 1'b0;
            r_out0_data  <= '0;
            r_out0_last  <= 1'b0;
            r_out1_valid <= 1'b0;
            r_out1_data  <= '0;
            r_out1_last  <= 1'b0;
        end else begin
            if (w_load0) begin
                r_out0_valid <= 1'b1;
                r_out0_data  <= i_in_data;
                r_out0_last  <= i_in_last;
            end else if (i_out0_ready) begin
                r_out0_valid <= 1'b0;
            end
            if (w_load1) begin
                r_out1_valid <= 1'b1;
                r_out1_data  <= i_in_data;
                r_out1_last  <= i_in_last;
            end else if (i_out1_ready) begin
                r_out1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_inc0 && (r_pkt_cnt0 != CNT_MAX)) begin
                r_pkt_cnt0 <= r_pkt_cnt0 + CNT_ONE;
            end
            if (w_inc1 && (r_pkt_cnt1 != CNT_MAX)) begin
                r_pkt_cnt1 <= r_pkt_cnt1 + CNT_ONE;
            end
            if (w_inc_drop && (r_drop_cnt != CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out0_valid = r_out0_valid;
    assign o_out0_data  = r_out0_data;
    assign o_out0_last  = r_out0_last;
    assign o_out1_valid = r_out1_valid;
    assign o_out1_data  = r_out1_data;
    assign o_out1_last  = r_out1_last;
    assign o_busy       = r_busy;
    assign o_cur_port   = r_cur_port;
    assign o_pkt_cnt0   = r_pkt_cnt0;
    assign o_pkt_cnt1   = r_pkt_cnt1;
    assign o_drop_cnt   = r_drop_cnt;

endmodule
